// File: rtl/axi_pipe_chain.sv
// Elastic register chain: each stage adds INC to the payload and moves beats forward under valid/ready flow control.
// Optional input skid slot enabled by defining AXI_PIPE_CHAIN_SKID_EN.
module axi_pipe_chain #(
    parameter int          DWIDTH = 8,
    parameter int          STAGES = 2,
    parameter int unsigned INC    = 1
) (
    input  logic                          aclk_i,
    input  logic                          areset_i,
    input  logic                          valid_i,
    input  logic [DWIDTH-1:0]             data_i,
    output logic                          ready_o,
    output logic                          valid_o,
    output logic [DWIDTH-1:0]             data_o,
    input  logic                          ready_i,
    output logic [$clog2(STAGES+2)-1:0]   count_o
);

    localparam int CW = $clog2(STAGES+2);
    localparam logic [DWIDTH-1:0] INC_W = DWIDTH'(INC);

    // A beat moves across an interface only on a cycle where valid and ready are both 1;
    // valid never depends on ready, and a presented beat is held until it is taken.
    logic [STAGES-1:0] stage_valid;
    logic [DWIDTH-1:0] stage_data [STAGES];
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] src_valid;
    logic [DWIDTH-1:0] src_data [STAGES];
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_xfer;
    logic              out_xfer;
    logic [CW-1:0]     count_q;

    // Stage k can load if it or any later stage has a hole, or the sink is taking a beat.
    always_comb begin
        stage_ready = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_ready[k] = ready_i;
            for (int j = k; j < STAGES; j++) begin
                if (!stage_valid[j]) stage_ready[k] = 1'b1;
            end
        end
    end

    always_comb begin
        src_valid = '0;
        for (int k = 0; k < STAGES; k++) src_data[k] = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = stage_valid[k-1];
            src_data[k]  = stage_data[k-1];
        end
    end

`ifdef AXI_PIPE_CHAIN_SKID_EN
    logic              skid_valid;
    logic [DWIDTH-1:0] skid_data;

    assign ready_o  = ~skid_valid;
    assign in_valid = skid_valid | valid_i;
    assign in_data  = skid_valid ? skid_data : data_i;

    // The slot catches the beat accepted on a cycle where stage 0 is blocked.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            if (stage_ready[0]) skid_valid <= 1'b0;
        end else if (valid_i && !stage_ready[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= data_i;
        end
    end
`else
    assign ready_o  = stage_ready[0];
    assign in_valid = valid_i;
    assign in_data  = data_i;
`endif

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    // Data only loads with a valid beat so a bubble leaves the old payload in place.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            stage_valid <= '0;
            for (int k = 0; k < STAGES; k++) stage_data[k] <= '0;
            count_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (stage_ready[k]) begin
                    stage_valid[k] <= src_valid[k];
                    if (src_valid[k]) stage_data[k] <= src_data[k] + INC_W;
                end
            end
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    assign valid_o = stage_valid[STAGES-1];
    assign data_o  = stage_data[STAGES-1];
    assign count_o = count_q;

endmodule

// File: doc/axi_pipe_chain.md
AXI_PIPE_CHAIN -- requirements
Module: axi_pipe_chain

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, the payload width in bits (range 1..64).
REQ-002 SHALL have parameter STAGES, default 2, the number of register stages in the chain (range 1..16).
REQ-003 SHALL have parameter INC, default 1, the value added to the payload at each stage (DWIDTH-bit unsigned).
REQ-004 SHALL have port aclk_i  input  1  the clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port areset_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port valid_i  input  1  upstream beat valid.
REQ-007 SHALL have port data_i  input  DWIDTH  upstream payload.
REQ-008 SHALL have port ready_o  output  1  upstream may transfer this cycle.
REQ-009 SHALL have port valid_o  output  1  downstream beat valid, registered.
REQ-010 SHALL have port data_o  output  DWIDTH  downstream payload, registered.
REQ-011 SHALL have port ready_i  input  1  downstream accepts this cycle.
REQ-012 SHALL have port count_o  output  $clog2(STAGES+2)  beats currently held, registered.

Function
REQ-013 SHALL transfer a beat upstream only when valid_i and ready_o are both 1, and downstream only when valid_o and ready_i are both 1.
REQ-014 SHALL implement STAGES valid/data register pairs; stage k loads from stage k-1 (stage 0 from the input) when stage k is empty or stage k+1 accepts in the same cycle.
REQ-015 SHALL make stage k's data equal to (stage k-1 data + INC) mod 2^DWIDTH, so data_o = (data_i + STAGES*INC) mod 2^DWIDTH with silent wrap-around.
REQ-016 SHALL give a latency of exactly STAGES cycles from an accepted input to valid_o with ready_i held 1.
REQ-017 SHALL sustain one beat per cycle with ready_i held 1 and valid_i held 1.
REQ-018 SHALL never drop, duplicate or reorder beats under any valid_i/ready_i pattern.
REQ-019 SHALL hold valid_o and data_o stable while valid_o=1 and ready_i=0.
REQ-020 SHALL fill all STAGES stages (plus the skid slot, when present) under sustained ready_i=0 before deasserting ready_o.
REQ-021 SHALL update count_o each cycle by +1 on an input transfer only, -1 on an output transfer only, and 0 on both or neither.
REQ-022 SHALL keep the full chain at full throughput when an input and an output transfer occur in the same cycle.

Reset
REQ-023 SHALL, while areset_i=1 at a clock edge, clear every stage valid, every stage data register, the skid slot, valid_o, data_o and count_o to 0.
REQ-024 SHALL drive ready_o=1 in the first cycle after reset deasserts.
REQ-025 SHALL discard beats held when reset is asserted mid-operation; no held beat appears on the output after reset.

Configuration
REQ-026 SHALL, with AXI_PIPE_CHAIN_SKID_EN defined, add a one-beat skid slot at the input, making ready_o = NOT skid_valid; the slot fills only when stage 0 cannot load, stage 0 loads from the slot before data_i, and the combinational path ready_i-to-ready_o is removed.
REQ-027 SHALL, without AXI_PIPE_CHAIN_SKID_EN, drive ready_o = NOT valid(stage0) OR ready(stage1) combinationally through the chain to ready_i, have no skid slot, and make count_o max STAGES.

Verification
REQ-028 SHALL cover: DWIDTH=8, STAGES=2, INC=1, ready_i=1, inputs 0x10,0x11,0x12 back-to-back -> outputs 0x12,0x13,0x14 on cycles 2,3,4 after the first accept.
REQ-029 SHALL cover: DWIDTH=8, STAGES=3, INC=1, input 0xFE -> output 0x01 (wrap-around).
REQ-030 SHALL cover: STAGES=4, ready_i=0, valid_i=1 continuously -> ready_o falls after 4 accepts (5 with skid), count_o=4 (5); then ready_i=1 -> all beats drain in order with no loss.
REQ-031 SHALL cover: random valid_i/ready_i at 50% for 10000 beats -> scoreboard shows in-order, exact data_i+STAGES*INC on every beat and count_o matching the model every cycle.
REQ-032 SHALL cover: areset_i=1 for one cycle with the chain full -> next cycle valid_o=0, data_o=0, count_o=0, ready_o=1.
REQ-033 SHALL cover: with AXI_PIPE_CHAIN_SKID_EN defined -> ready_o is a flop output and does not change in the same cycle as ready_i.
